// File: rtl/truth_table_sequencer.sv
// ============================================================================
// Module      : truth_table_sequencer
// Description : Walks every input vector of an N-input function, samples its
//               output after a settle window and scores it against an
//               expected truth table. Optional macro TTS_ABORT_ON_ERR_EN ends
//               the scan on the first mismatching sample.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module truth_table_sequencer #(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2**N-1:0]   expected,
  input  logic              f_in,
  output logic [N-1:0]      x,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   table_o,
  output logic [N:0]        errors,
  output logic              pass
);

  localparam logic [1:0]   S_IDLE = 2'd0;
  localparam logic [1:0]   S_HOLD = 2'd1;
  localparam logic [1:0]   S_FIN  = 2'd2;

  localparam logic [7:0]   c_settle = 8'(SETTLE);
  localparam logic [N-1:0] c_last_x = {N{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [7:0]        r_cnt;
  logic [N-1:0]      r_x;
  logic              r_busy;
  logic              r_done;
  logic [2**N-1:0]   r_table;
  logic [N:0]        r_errors;
  logic              r_pass;

  logic              w_accept;
  logic              w_sample;
  logic              w_mismatch;
  logic              w_abort;
  logic              w_finish;
  logic [N:0]        w_errors_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_HOLD;
      S_HOLD:  if (w_finish) w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Decode of the current cycle's actions
  always_comb begin
    w_accept      = (r_state == S_IDLE) && start;
    w_sample      = (r_state == S_HOLD) && (r_cnt == 8'd0);
    w_mismatch    = w_sample && (f_in != expected[r_x]);
    w_errors_next = r_errors + {{N{1'b0}}, w_mismatch};
`ifdef TTS_ABORT_ON_ERR_EN
    w_abort       = w_mismatch;
`else
    w_abort       = 1'b0;
`endif
    w_finish      = w_sample && ((r_x == c_last_x) || w_abort);
  end

  // Datapath: vector counter, settle counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= '0;
      r_cnt    <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= '0;
      r_errors <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x      <= '0;
        r_cnt    <= c_settle;
        r_table  <= '0;
        r_errors <= '0;
        r_pass   <= 1'b0;
        r_busy   <= 1'b1;
      end else if (r_state == S_HOLD) begin
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_table[r_x] <= f_in;
          r_errors     <= w_errors_next;
          if (w_finish) begin
            // x stays on the final (or failing) vector after the scan
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_errors_next == '0);
          end else begin
            r_x   <= r_x + N'(1);
            r_cnt <= c_settle;
          end
        end
      end
    end
  end

  assign x       = r_x;
  assign busy    = r_busy;
  assign done    = r_done;
  assign table_o = r_table;
  assign errors  = r_errors;
  assign pass    = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// ============================================================================
// Module      : tb_truth_table_sequencer
// Description : Self-checking bench; random function/expected tables scored
//               against a truth-table level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sequencer;

  localparam int N      = 3;
  localparam int SETTLE = 2;
  localparam int V      = 2**N;
  localparam int L_FULL = V * (SETTLE + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [V-1:0] expected;
  logic [V-1:0] func_tt;
  logic         f_in;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic [V-1:0] table_o;
  logic [N:0]   errors;
  logic         pass;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Function under test: a pure lookup of the current vector
  assign f_in = func_tt[x];

  truth_table_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .expected (expected),
    .f_in     (f_in),
    .x        (x),
    .busy     (busy),
    .done     (done),
    .table_o  (table_o),
    .errors   (errors),
    .pass     (pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan with cycle-exact checks against the truth-table model
  task automatic run_scan(input logic [V-1:0] ftt, input logic [V-1:0] ex,
                          input int repulse_at, input bit start_in_fin);
    int           errs;
    int           lat;
    int           ex_x;
    int           k;
    logic [V-1:0] ex_tab;
    errs   = $countones(ftt ^ ex);
    lat    = L_FULL;
    ex_tab = ftt;
    ex_x   = V - 1;
    k      = 0;
`ifdef TTS_ABORT_ON_ERR_EN
    if (errs != 0) begin
      while (ftt[k] == ex[k]) k++;
      lat    = (k + 1) * (SETTLE + 1);
      ex_tab = ftt & V'((1 << (k + 1)) - 1);
      errs   = 1;
      ex_x   = k;
    end
`endif
    func_tt  = ftt;
    expected = ex;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",   32'(busy),    32'd1);
    chk("start_x",      32'(x),       32'd0);
    chk("start_table",  32'(table_o), 32'd0);
    chk("start_errors", 32'(errors),  32'd0);
    chk("start_pass",   32'(pass),    32'd0);
    chk("start_done",   32'(done),    32'd0);
    for (int t = 1; t < lat; t++) begin
      start = (t == repulse_at) ? 1'b1 : 1'b0;
      tick();
      chk("scan_x",    32'(x),    32'(t / (SETTLE + 1)));
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    tick();
    chk("fin_done",   32'(done),    32'd1);
    chk("fin_busy",   32'(busy),    32'd0);
    chk("fin_table",  32'(table_o), 32'(ex_tab));
    chk("fin_errors", 32'(errors),  32'(errs));
    chk("fin_pass",   32'(pass),    32'(errs == 0));
    chk("fin_x",      32'(x),       32'(ex_x));
    start = start_in_fin;
    tick();
    start = 1'b0;
    chk("post_done",   32'(done),    32'd0);
    chk("post_busy",   32'(busy),    32'd0);
    chk("post_x",      32'(x),       32'(ex_x));
    chk("post_table",  32'(table_o), 32'(ex_tab));
    chk("post_errors", 32'(errors),  32'(errs));
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pass", 32'(pass), 32'(errs == 0));
  endtask

  initial begin
    logic [V-1:0] r_ftt;
    logic [V-1:0] r_ex;
    reset    = 1'b1;
    start    = 1'b0;
    func_tt  = '0;
    expected = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_x",      32'(x),       32'd0);
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_done",   32'(done),    32'd0);
    chk("rst_table",  32'(table_o), 32'd0);
    chk("rst_errors", 32'(errors),  32'd0);
    chk("rst_pass",   32'(pass),    32'd0);

    // Parity function, matching and fully inverted expectations
    run_scan(8'b1001_0110, 8'b1001_0110, -1, 1'b0);
    run_scan(8'b1001_0110, 8'b0110_1001, -1, 1'b1);
    // Product-of-sums function with matching minterm mask
    run_scan(8'b1110_1001, 8'b1110_1001, 5, 1'b0);

    // Random functions: exact match, all-mismatch, single flipped minterm, random
    for (int i = 0; i < 8; i++) begin
      r_ftt = V'($urandom);
      case (i % 4)
        0:       r_ex = r_ftt;
        1:       r_ex = ~r_ftt;
        2:       r_ex = r_ftt ^ V'(1 << $urandom_range(V - 1, 0));
        default: r_ex = V'($urandom);
      endcase
      run_scan(r_ftt, r_ex, (i % 2 == 0) ? int'($urandom_range(L_FULL - 1, 1)) : -1, i[0]);
    end

    // Reset mid-scan: abort without a done pulse
    func_tt  = 8'hA5;
    expected = 8'hA5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 7; t++) tick();
    chk("pre_rst_table", 32'(table_o), 32'h1);
    chk("pre_rst_x",     32'(x),       32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_x",      32'(x),       32'd0);
    chk("mid_rst_busy",   32'(busy),    32'd0);
    chk("mid_rst_errors", 32'(errors),  32'd0);
    chk("mid_rst_pass",   32'(pass),    32'd0);
    chk("mid_rst_table",  32'(table_o), 32'd0);
    for (int t = 0; t < L_FULL; t++) begin
      chk("no_done_after_rst", 32'(done), 32'd0);
      tick();
    end
    run_scan(8'b1001_0110, 8'b1001_0110, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
